// File: rtl/memory_access_stage_pkg.sv
// rtl/memory_access_stage_pkg.sv - Y86-64 constants and data-memory FSM encodings for the M stage
package memory_access_stage_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    // Stage status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_REQ  = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    // An 8-byte access is legal when addr + 8 <= mem_bytes; written as a
    // subtraction on the limit so a huge addr cannot wrap into range.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] mem_bytes);
        return (mem_bytes >= 64'd8) && (addr <= (mem_bytes - 64'd8));
    endfunction

endpackage

// File: rtl/memory_access_stage_dmem_access_fsm.sv
// rtl/memory_access_stage_dmem_access_fsm.sv - data-memory request FSM with request latch and response capture
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   start_i                   issue an access this cycle (only honoured in IDLE)
//   addr_i, we_i, wdata_i     access fields latched on start
//   advance_i                 M register loads; releases DONE
//   dmem_*                    registered request / response handshake
//   state_o                   current FSM state
//   valM_o, stat_o            captured response
import memory_access_stage_pkg::*;

module dmem_access_fsm (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [63:0] addr_i,
    input  logic        we_i,
    input  logic [63:0] wdata_i,
    input  logic        advance_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output dmem_state_e state_o,
    output logic [63:0] valM_o,
    output logic [2:0]  stat_o
);

    dmem_state_e state_q, state_d;
    logic [63:0] addr_q, wdata_q, valM_q;
    logic        we_q;
    logic [2:0]  stat_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= DMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: if (start_i)    state_d = DMEM_REQ;
            DMEM_REQ:  if (dmem_ack_i) state_d = DMEM_DONE;
            DMEM_DONE: if (advance_i)  state_d = DMEM_IDLE;
            default:                   state_d = DMEM_IDLE;
        endcase
    end

    // Request fields are only written in IDLE, so they stay stable for the
    // whole REQ phase; the response is only written on the ack in REQ, so
    // ack while idle or done is ignored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            valM_q  <= '0;
            stat_q  <= SAOK;
        end else begin
            if (state_q == DMEM_IDLE && start_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                we_q    <= we_i;
            end
            if (state_q == DMEM_REQ && dmem_ack_i) begin
                valM_q <= (dmem_err_i || we_q) ? 64'd0 : dmem_rdata_i;
                stat_q <= dmem_err_i ? SADR : SAOK;
            end
        end
    end

    assign dmem_req_o   = (state_q == DMEM_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign state_o      = state_q;
    assign valM_o       = valM_q;
    assign stat_o       = stat_q;

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - Y86-64 M stage with multi-cycle req/ack data-memory port
//
// Ports:
//   clk_i, rst_n_i                         clock, asynchronous active-low reset
//   M_stat_i, M_icode_i, M_valE_i, M_valA_i  M pipeline register contents
//   m_advance_i                            M register loads at next edge
//   m_stat_o, m_valM_o                     result for the W register
//   m_stall_req_o                          stall F/D/E/M, bubble W
//   dmem_req_o/we_o/addr_o/wdata_o         registered memory request
//   dmem_ack_i/rdata_i/err_i               memory response
import memory_access_stage_pkg::*;

module memory_access_stage #(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    input  logic        m_advance_i,
    output logic [2:0]  m_stat_o,
    output logic [63:0] m_valM_o,
    output logic        m_stall_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    input  logic        dmem_err_i
);

    logic        is_read, is_write, need, in_range, start;
    logic [63:0] addr;
    logic [63:0] fsm_valM;
    logic [2:0]  fsm_stat;
    dmem_state_e state;

    always_comb begin
        is_read  = (M_icode_i == IMRMOVQ) || (M_icode_i == IPOPQ) || (M_icode_i == IRET);
        is_write = (M_icode_i == IRMMOVQ) || (M_icode_i == IPUSHQ) || (M_icode_i == ICALL);
        // popq and ret read through the stack pointer carried in valA
        addr     = ((M_icode_i == IPOPQ) || (M_icode_i == IRET)) ? M_valA_i : M_valE_i;
        need     = (M_stat_i == SAOK) && (is_read || is_write);
        in_range = addr_in_range(addr, 64'(MEM_BYTES));
        start    = need && in_range && (state == DMEM_IDLE);
    end

    dmem_access_fsm u_fsm (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start),
        .addr_i       (addr),
        .we_i         (is_write),
        .wdata_i      (M_valA_i),
        .advance_i    (m_advance_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_err_i   (dmem_err_i),
        .state_o      (state),
        .valM_o       (fsm_valM),
        .stat_o       (fsm_stat)
    );

    // Reset gates the combinational outputs too, so every output shows its
    // reset value while rst_n_i is low regardless of what M still holds.
    always_comb begin
        m_stat_o      = M_stat_i;
        m_valM_o      = 64'd0;
        m_stall_req_o = 1'b0;
        if (!rst_n_i) begin
            m_stat_o = SAOK;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    m_stall_req_o = need && in_range;
                    if (need && !in_range) m_stat_o = SADR;
                end
                DMEM_REQ:  m_stall_req_o = 1'b1;
                DMEM_DONE: begin
                    m_stat_o = fsm_stat;
                    m_valM_o = fsm_valM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - self-checking bench for memory_access_stage
module tb_memory_access_stage;

    localparam int unsigned MEMB = 8192;
    localparam logic [2:0] SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3, SINS = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  M_stat = SAOK;
    logic [3:0]  M_icode = 4'h1;
    logic [63:0] M_valE = '0, M_valA = '0;
    logic        m_advance = 1'b0;
    logic [2:0]  m_stat;
    logic [63:0] m_valM;
    logic        stall, req, we;
    logic [63:0] addr, wdata;
    logic        ack = 1'b0, err = 1'b0;
    logic [63:0] rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.MEM_BYTES(MEMB)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .M_stat_i(M_stat), .M_icode_i(M_icode), .M_valE_i(M_valE), .M_valA_i(M_valA),
        .m_advance_i(m_advance),
        .m_stat_o(m_stat), .m_valM_o(m_valM), .m_stall_req_o(stall),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
        .dmem_ack_i(ack), .dmem_rdata_i(rdata), .dmem_err_i(err)
    );

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE, valA, rd;
        int          waits;
        logic        er;
        int          hold;
        logic [63:0] e_valM;
        logic [2:0]  e_stat;
        int          e_req, e_stall;
        logic        e_we;
        logic [63:0] e_addr, e_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] icode, input logic [2:0] stat,
                                input logic [63:0] valE, input logic [63:0] valA, input logic [63:0] rd,
                                input int waits, input logic er, input int hold,
                                input logic [63:0] e_valM, input logic [2:0] e_stat,
                                input int e_req, input int e_stall, input logic e_we,
                                input logic [63:0] e_addr, input logic [63:0] e_wdata);
        vec_t v;
        v.name = name; v.icode = icode; v.stat = stat; v.valE = valE; v.valA = valA; v.rd = rd;
        v.waits = waits; v.er = er; v.hold = hold; v.e_valM = e_valM; v.e_stat = e_stat;
        v.e_req = e_req; v.e_stall = e_stall; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Reference: derived from the instruction's memory semantics, not from any state machine.
    function automatic vec_t model(input vec_t s);
        vec_t v = s;
        bit rd_op = (s.icode == 4'h5) || (s.icode == 4'hB) || (s.icode == 4'h9);
        bit wr_op = (s.icode == 4'h4) || (s.icode == 4'hA) || (s.icode == 4'h8);
        logic [63:0] a = ((s.icode == 4'hB) || (s.icode == 4'h9)) ? s.valA : s.valE;
        v.e_valM = 0; v.e_stat = s.stat; v.e_req = 0; v.e_stall = 0;
        v.e_we = wr_op; v.e_addr = a; v.e_wdata = s.valA;
        if (s.stat == SAOK && (rd_op || wr_op)) begin
            if (a > 64'(MEMB - 8)) begin
                v.e_stat = SADR;
            end else begin
                v.e_req   = s.waits + 1;
                v.e_stall = s.waits + 2;
                v.e_stat  = s.er ? SADR : SAOK;
                v.e_valM  = (rd_op && !s.er) ? s.rd : 64'd0;
            end
        end
        return v;
    endfunction

    // Entered at negedge+1; returns at negedge+1 after advancing M to a nop.
    task automatic run(input vec_t v);
        int reqs = 0, stalls = 0, left = v.waits, it = 0;
        bit done = 0;
        M_icode = v.icode; M_stat = v.stat; M_valE = v.valE; M_valA = v.valA;
        m_advance = 0; ack = 0; err = 0; rdata = 0;
        #1;
        while (!done && it < 40) begin
            it++;
            ack = 0; err = 0; rdata = 0;
            if (stall) stalls++;
            if (req) begin
                reqs++;
                chk({v.name, " addr"}, addr, v.e_addr);
                chk({v.name, " we"}, 64'(we), 64'(v.e_we));
                if (v.e_we) chk({v.name, " wdata"}, wdata, v.e_wdata);
                if (left == 0) begin
                    ack = 1; err = v.er; rdata = v.rd;
                end else begin
                    left--;
                end
            end
            if (!stall && !req) done = 1;
            else begin
                @(negedge clk); #1;
            end
        end
        if (!done) chk({v.name, " timeout"}, 64'(it), 64'(0));
        chk({v.name, " valM"}, m_valM, v.e_valM);
        chk({v.name, " stat"}, 64'(m_stat), 64'(v.e_stat));
        chk({v.name, " req_cycles"}, 64'(reqs), 64'(v.e_req));
        chk({v.name, " stall_cycles"}, 64'(stalls), 64'(v.e_stall));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk); #1;
            chk({v.name, " hold req"}, 64'(req), 64'(0));
            chk({v.name, " hold stall"}, 64'(stall), 64'(0));
            chk({v.name, " hold valM"}, m_valM, v.e_valM);
            chk({v.name, " hold stat"}, 64'(m_stat), 64'(v.e_stat));
        end
        m_advance = 1; M_icode = 4'h1; M_stat = SAOK;
        @(negedge clk); #1;
        m_advance = 0;
        chk({v.name, " after advance stat"}, 64'(m_stat), 64'(SAOK));
        chk({v.name, " after advance valM"}, m_valM, 64'd0);
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = mk("mrmovq_wait2", 4'h5, SAOK, 64'h100, 64'h0, 64'hDEADBEEF, 2, 0, 0,
                    64'hDEADBEEF, SAOK, 3, 4, 0, 64'h100, 64'h0);
        tbl[1] = mk("pushq", 4'hA, SAOK, 64'h1F8, 64'h55, 64'hFFFF, 0, 0, 0,
                    64'h0, SAOK, 1, 2, 1, 64'h1F8, 64'h55);
        tbl[2] = mk("rmmovq_oob", 4'h4, SAOK, 64'h1FF9, 64'h9, 64'h0, 0, 0, 0,
                    64'h0, SADR, 0, 0, 1, 64'h1FF9, 64'h9);
        tbl[3] = mk("popq_err", 4'hB, SAOK, 64'h0, 64'h40, 64'h77, 0, 1, 0,
                    64'h0, SADR, 1, 2, 0, 64'h40, 64'h40);
        tbl[4] = mk("mrmovq_hold3", 4'h5, SAOK, 64'h200, 64'h0, 64'h1234, 0, 0, 3,
                    64'h1234, SAOK, 1, 2, 0, 64'h200, 64'h0);
        tbl[5] = mk("rmmovq_edge", 4'h4, SAOK, 64'h1FF8, 64'h7, 64'h0, 1, 0, 0,
                    64'h0, SAOK, 2, 3, 1, 64'h1FF8, 64'h7);
        tbl[6] = mk("nop", 4'h1, SAOK, 64'h10, 64'h20, 64'h0, 0, 0, 0,
                    64'h0, SAOK, 0, 0, 0, 64'h10, 64'h20);
        tbl[7] = mk("ret_wait1", 4'h9, SAOK, 64'h0, 64'h1FF8, 64'hABC, 1, 0, 0,
                    64'hABC, SAOK, 2, 3, 0, 64'h1FF8, 64'h1FF8);
        tbl[8] = mk("mrmovq_shlt", 4'h5, SHLT, 64'h100, 64'h0, 64'h5, 0, 0, 0,
                    64'h0, SHLT, 0, 0, 0, 64'h100, 64'h0);

        // reset values
        #2;
        chk("reset req", 64'(req), 0);
        chk("reset stall", 64'(stall), 0);
        chk("reset stat", 64'(m_stat), 64'(SAOK));
        chk("reset valM", m_valM, 0);
        chk("reset addr", addr, 0);
        chk("reset wdata", wdata, 0);
        chk("reset we", 64'(we), 0);
        @(negedge clk); rst_n = 1; #1;

        for (int i = 0; i < 9; i++) run(tbl[i]);

        // ack with no request outstanding is ignored
        ack = 1; err = 1; rdata = 64'h99;
        @(negedge clk); #1;
        chk("stray ack req", 64'(req), 0);
        chk("stray ack stall", 64'(stall), 0);
        chk("stray ack stat", 64'(m_stat), 64'(SAOK));
        chk("stray ack valM", m_valM, 0);
        ack = 0; err = 0; rdata = 0;

        // reset while in REQ
        M_icode = 4'h5; M_stat = SAOK; M_valE = 64'h80;
        @(negedge clk); #1;
        chk("pre-reset req", 64'(req), 1);
        rst_n = 0; #1;
        chk("async reset req", 64'(req), 0);
        chk("async reset stall", 64'(stall), 0);
        chk("async reset stat", 64'(m_stat), 64'(SAOK));
        chk("async reset valM", m_valM, 0);
        chk("async reset addr", addr, 0);
        chk("async reset we", 64'(we), 0);
        @(negedge clk); rst_n = 1; M_stat = SINS; #1;
        for (int k = 0; k < 2; k++) begin
            chk("sins req", 64'(req), 0);
            chk("sins stall", 64'(stall), 0);
            chk("sins stat", 64'(m_stat), 64'(SINS));
            @(negedge clk); #1;
        end
        M_stat = SAOK; M_icode = 4'h1;
        @(negedge clk); #1;

        // randomized against the reference model
        for (int r = 0; r < 60; r++) begin
            vec_t v;
            v.name = $sformatf("rand%0d", r);
            v.icode = 4'($urandom_range(0, 11));
            v.stat = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
            for (int s = 0; s < 2; s++) begin
                logic [63:0] a;
                case ($urandom_range(0, 5))
                    0: a = 64'(MEMB - 8);
                    1: a = 64'(MEMB - 7);
                    2: a = {$urandom, $urandom};
                    default: a = 64'($urandom_range(0, MEMB - 8));
                endcase
                if (s == 0) v.valE = a; else v.valA = a;
            end
            v.rd = {$urandom, $urandom};
            v.waits = $urandom_range(0, 3);
            v.er = ($urandom_range(0, 7) == 0);
            v.hold = $urandom_range(0, 2);
            run(model(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
